// File: rtl/elevator_pkg.sv
// Shared types and constants for the SCAN elevator controller.
package elevator_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MOVE = 2'd1,
    ST_DOOR = 2'd2
  } state_e;

  localparam logic DIR_UP   = 1'b1;
  localparam logic DIR_DOWN = 1'b0;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/elev_dwell_timer.sv
// Loadable down-counter with zero flag; times both floor travel and door dwell.
module elev_dwell_timer #(
  parameter int W = 3
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic         dec,
  input  logic [W-1:0] load_val,
  output logic         zero
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load)                     cnt_d = load_val;
    else if (dec && cnt_q != '0)  cnt_d = cnt_q - W'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign zero = (cnt_q == '0);

endmodule

// File: rtl/elevator_scan_scheduler.sv
// Elevator car controller: latches floor calls and serves them in SCAN order
// with timed floor-to-floor travel and door dwell.
module elevator_scan_scheduler
  import elevator_pkg::*;
#(
  parameter  int NUM_FLOORS = 4,
  parameter  int TRAVEL_CYC = 4,
  parameter  int DOOR_CYC   = 3,
  localparam int FLOOR_W    = $clog2(NUM_FLOORS)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NUM_FLOORS-1:0] call_req,
  output logic [FLOOR_W-1:0]    current_floor,
  output logic                  direction,
  output logic                  moving,
  output logic                  door,
  output logic [NUM_FLOORS-1:0] pending,
  output logic                  busy
);

  localparam int TMR_W = $clog2(max_int(TRAVEL_CYC, DOOR_CYC) + 1);

  state_e                state_q, state_d;
  logic                  dir_q, dir_d;
  logic [FLOOR_W-1:0]    floor_q, floor_d;
  logic [NUM_FLOORS-1:0] pending_q, pending_d;
  logic [NUM_FLOORS-1:0] above, below, ahead, behind, floor_onehot, clr_mask;
  logic                  tmr_load, tmr_dec, tmr_zero;
  logic [TMR_W-1:0]      tmr_val;

  always_comb begin
    above = '0;
    below = '0;
    for (int f = 0; f < NUM_FLOORS; f++) begin
      if (FLOOR_W'(f) > floor_q) above[f] = pending_q[f];
      if (FLOOR_W'(f) < floor_q) below[f] = pending_q[f];
    end
    ahead        = (dir_q == DIR_UP) ? above : below;
    behind       = (dir_q == DIR_UP) ? below : above;
    floor_onehot = NUM_FLOORS'(1) << floor_q;
  end

  always_comb begin
    state_d  = state_q;
    dir_d    = dir_q;
    floor_d  = floor_q;
    tmr_load = 1'b0;
    tmr_dec  = 1'b0;
    tmr_val  = '0;
    clr_mask = '0;
    unique case (state_q)
      ST_IDLE: begin
        if (pending_q[floor_q]) begin
          state_d  = ST_DOOR;
          tmr_load = 1'b1;
          tmr_val  = TMR_W'(DOOR_CYC - 1);
          clr_mask = floor_onehot;
        end else if (|ahead) begin
          state_d  = ST_MOVE;
          tmr_load = 1'b1;
          tmr_val  = TMR_W'(TRAVEL_CYC - 1);
        end else if (|behind) begin
          state_d  = ST_MOVE;
          dir_d    = ~dir_q;
          tmr_load = 1'b1;
          tmr_val  = TMR_W'(TRAVEL_CYC - 1);
        end
      end
      ST_MOVE: begin
        if (tmr_zero) begin
          state_d = ST_IDLE;
          // Clamp guards the rails even though a target always lies ahead.
          if (dir_q == DIR_UP) begin
            if (floor_q != FLOOR_W'(NUM_FLOORS - 1)) floor_d = floor_q + FLOOR_W'(1);
          end else begin
            if (floor_q != '0) floor_d = floor_q - FLOOR_W'(1);
          end
        end else begin
          tmr_dec = 1'b1;
        end
      end
      ST_DOOR: begin
        clr_mask = floor_onehot;
        if (call_req[floor_q]) begin
          tmr_load = 1'b1;
          tmr_val  = TMR_W'(DOOR_CYC - 1);
        end else if (tmr_zero) begin
          state_d = ST_IDLE;
        end else begin
          tmr_dec = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    pending_d = (pending_q | call_req) & ~clr_mask;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      dir_q     <= DIR_UP;
      floor_q   <= '0;
      pending_q <= '0;
    end else begin
      state_q   <= state_d;
      dir_q     <= dir_d;
      floor_q   <= floor_d;
      pending_q <= pending_d;
    end
  end

  elev_dwell_timer #(.W(TMR_W)) u_timer (
    .clk      (clk),
    .reset    (reset),
    .load     (tmr_load),
    .dec      (tmr_dec),
    .load_val (tmr_val),
    .zero     (tmr_zero)
  );

  assign current_floor = floor_q;
  assign direction     = dir_q;
  assign moving        = (state_q == ST_MOVE);
  assign door          = (state_q == ST_DOOR);
  assign pending       = pending_q;
  assign busy          = (state_q != ST_IDLE) || (|pending_q);

endmodule

// File: tb/tb_elevator_scan_scheduler.sv
// Directed bench for the SCAN elevator controller (4-floor and 2-floor instances).
module tb_elevator_scan_scheduler;

  logic       clk = 1'b0;
  logic       reset, reset2;
  logic [3:0] call4;
  logic [1:0] call2;

  logic [1:0] floor4;
  logic       dir4, mov4, door4, busy4;
  logic [3:0] pend4;
  logic [0:0] floor2;
  logic       dir2, mov2, door2, busy2;
  logic [1:0] pend2;

  int n_total = 0;
  int n_pass  = 0;
  int exp_q[$];

  always #5 clk = ~clk;

  elevator_scan_scheduler #(.NUM_FLOORS(4), .TRAVEL_CYC(4), .DOOR_CYC(3)) dut4 (
    .clk(clk), .reset(reset), .call_req(call4), .current_floor(floor4),
    .direction(dir4), .moving(mov4), .door(door4), .pending(pend4), .busy(busy4)
  );

  elevator_scan_scheduler #(.NUM_FLOORS(2), .TRAVEL_CYC(4), .DOOR_CYC(3)) dut2 (
    .clk(clk), .reset(reset2), .call_req(call2), .current_floor(floor2),
    .direction(dir2), .moving(mov2), .door(door2), .pending(pend2), .busy(busy2)
  );

  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  function automatic logic door_of(input bit which2);
    return which2 ? door2 : door4;
  endfunction

  // Waits for the door to open, then pops the scoreboard and compares the floor.
  task automatic wait_open(input string tag, input bit which2);
    int c = 0;
    int expf;
    while (door_of(which2) !== 1'b1 && c < 200) begin
      tick();
      c++;
    end
    chk({tag, "_open"}, door_of(which2), 1);
    if (exp_q.size() == 0) begin
      chk({tag, "_sb_empty"}, exp_q.size(), 1);
    end else begin
      expf = exp_q.pop_front();
      chk({tag, "_floor"}, which2 ? 32'(floor2) : 32'(floor4), expf);
    end
  endtask

  task automatic wait_close(input string tag, input bit which2);
    int c = 0;
    while (door_of(which2) !== 1'b0 && c < 200) begin
      tick();
      c++;
    end
    chk({tag, "_close"}, door_of(which2), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; reset2 = 1'b1; call4 = '0; call2 = '0;
    tick(2);
    reset = 1'b0; reset2 = 1'b0;
    chk("rst_floor", floor4, 0);
    chk("rst_dir", dir4, 1);
    chk("rst_moving", mov4, 0);
    chk("rst_door", door4, 0);
    chk("rst_pending", pend4, 0);
    chk("rst_busy", busy4, 0);

    // Single call to floor 2: exact cycle timing.
    call4 = 4'b0100; tick(); call4 = '0;        // edge 0
    chk("t1_pend_e0", pend4, 4'b0100);
    chk("t1_mov_e0", mov4, 0);
    tick();                                     // edge 1
    chk("t1_mov_e1", mov4, 1);
    tick(4);                                    // edge 5
    chk("t1_floor_e5", floor4, 1);
    chk("t1_mov_e5", mov4, 0);
    tick(5);                                    // edge 10
    chk("t1_floor_e10", floor4, 2);
    tick();                                     // edge 11
    chk("t1_door_e11", door4, 1);
    chk("t1_pend_e11", pend4, 0);
    tick(2);                                    // edge 13
    chk("t1_door_e13", door4, 1);
    tick();                                     // edge 14
    chk("t1_door_e14", door4, 0);
    chk("t1_busy_e14", busy4, 0);

    // Call at the current floor opens the door for exactly DOOR_CYC cycles.
    reset = 1'b1; tick(); reset = 1'b0;
    call4 = 4'b0001; tick(); call4 = '0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("t2_door_hi", door4, 1);
      chk("t2_pend", pend4, 0);
    end
    tick();
    chk("t2_door_lo", door4, 0);

    // Moving up past floor 1 toward 3, a call for floor 0 arrives.
    exp_q.push_back(3);
    call4 = 4'b1000; tick(); call4 = '0;        // edge 0
    tick(6);                                    // edge 6: leaving floor 1
    exp_q.push_back(0);
    call4 = 4'b0001; tick(); call4 = '0;        // edge 7
    chk("t3_floor", floor4, 1);
    chk("t3_moving", mov4, 1);
    chk("t3_pend_both", pend4, 4'b1001);
    wait_open("t3_a", 1'b0);
    chk("t3_pend_after3", pend4, 4'b0001);
    wait_close("t3_a", 1'b0);
    tick();
    chk("t3_dir_down", dir4, 0);
    chk("t3_mov_down", mov4, 1);
    wait_open("t3_b", 1'b0);
    chk("t3_pend_after0", pend4, 4'b0000);
    wait_close("t3_b", 1'b0);

    // Door reopened by repeated calls for the current floor.
    exp_q.push_back(2);
    call4 = 4'b0100; tick(); call4 = '0;
    wait_open("t4", 1'b0);
    for (int i = 0; i < 5; i++) begin
      call4 = 4'b0100; tick();
      chk("t4_door_held", door4, 1);
      chk("t4_pend2", pend4[2], 0);
    end
    call4 = '0;
    tick(2);
    chk("t4_door_tail", door4, 1);
    tick();
    chk("t4_door_end", door4, 0);
    chk("t4_floor", floor4, 2);

    // Reset in the middle of a move discards everything.
    call4 = 4'b1010; tick(); call4 = '0;
    tick();
    chk("t5_moving", mov4, 1);
    chk("t5_pend", pend4, 4'b1010);
    reset = 1'b1; tick(); reset = 1'b0;
    chk("t5_floor", floor4, 0);
    chk("t5_dir", dir4, 1);
    chk("t5_moving0", mov4, 0);
    chk("t5_pend0", pend4, 0);
    chk("t5_busy0", busy4, 0);

    // Two-floor instance: serve floor 1 then back to floor 0.
    exp_q.push_back(1);
    call2 = 2'b10; tick(); call2 = '0;
    tick();
    exp_q.push_back(0);
    call2 = 2'b01; tick(); call2 = '0;
    chk("t6_pend", pend2, 2'b11);
    wait_open("t6_a", 1'b1);
    chk("t6_pend_a", pend2, 2'b01);
    wait_close("t6_a", 1'b1);
    wait_open("t6_b", 1'b1);
    chk("t6_dir", dir2, 0);
    chk("t6_pend_b", pend2, 2'b00);
    wait_close("t6_b", 1'b1);
    chk("t6_sb_drained", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
